tia_programmable_divider: RTL and testbench

TIA_PROGRAMMABLE_DIVIDER -- requirements
Module: tia_programmable_divider

---
 rtl/tia_pkg.sv | 21 ++
 rtl/tia_phase_decode.sv | 31 +++
 rtl/tia_programmable_divider.sv | 73 +++++++
 tb/tb_tia_programmable_divider.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/tia_pkg.sv
// ============================================================================
// Module      : tia_pkg
// Description : Shared constants and ratio clamp for the TIA divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tia_pkg;

    localparam int          c_default_width = 4;
    localparam int          c_default_div   = 3;
    localparam int unsigned c_min_div       = 2;

    // Ratios below two cannot form a two-phase period, so they are raised.
    function automatic int unsigned clamp_div(input int unsigned d);
        return (d < c_min_div) ? c_min_div : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tia_phase_decode.sv
// ============================================================================
// Module      : tia_phase_decode
// Description : Combinational decode of phase counter into phi_theta/phi1/phi2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tia_phase_decode #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] ratio,
    output logic             phi_theta,
    output logic             phi1,
    output logic             phi2
);

    logic [WIDTH-1:0] w_half;
    logic [WIDTH-1:0] w_phi2_start;

    // For odd ratios phi2 starts one count after phi1 ends, leaving a gap.
    assign w_half       = ratio >> 1;
    assign w_phi2_start = ratio - w_half;

    assign phi_theta = (count == '0);
    assign phi1      = (count <  w_half);
    assign phi2      = (count >= w_phi2_start);

endmodule

`default_nettype wire

// File: rtl/tia_programmable_divider.sv
// ============================================================================
// Module      : tia_programmable_divider
// Description : Programmable two-phase clock divider with sync restart.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tia_programmable_divider
    import tia_pkg::*;
#(
    parameter int WIDTH       = c_default_width,
    parameter int DEFAULT_DIV = c_default_div
) (
    input  logic             clk,
    input  logic             resphi0,
    input  logic [WIDTH-1:0] div,
    input  logic             div_load,
    input  logic             rsyn,
    output logic             phi_theta,
    output logic             phi1,
    output logic             phi2,
    output logic             rsyn_gated,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_reset_ratio = WIDTH'(clamp_div(DEFAULT_DIV));

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_pending;

    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_pending_next;
    logic             w_wrap;

    assign w_load_val     = WIDTH'(clamp_div(32'(div)));
    // A load coinciding with a boundary or restart takes effect on that edge.
    assign w_pending_next = div_load ? w_load_val : r_pending;
    assign w_wrap         = (r_count == (r_active - c_one));

    always_ff @(posedge clk) begin
        if (resphi0) begin
            r_count   <= '0;
            r_active  <= c_reset_ratio;
            r_pending <= c_reset_ratio;
        end else begin
            r_pending <= w_pending_next;
            if (rsyn || w_wrap) begin
                r_count  <= '0;
                r_active <= w_pending_next;
            end else begin
                r_count  <= r_count + c_one;
            end
        end
    end

    tia_phase_decode #(
        .WIDTH     (WIDTH)
    ) u_phase_decode (
        .count     (r_count),
        .ratio     (r_active),
        .phi_theta (phi_theta),
        .phi1      (phi1),
        .phi2      (phi2)
    );

    assign rsyn_gated = rsyn & ~phi_theta;
    assign count      = r_count;

endmodule

`default_nettype wire

// File: tb/tb_tia_programmable_divider.sv
// ============================================================================
// Module      : tb_tia_programmable_divider
// Description : Scoreboard bench for tia_programmable_divider, directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tia_programmable_divider;

    logic       clk = 1'b0;
    logic       resphi0;
    logic [3:0] div;
    logic       div_load;
    logic       rsyn;
    logic       phi_theta;
    logic       phi1;
    logic       phi2;
    logic       rsyn_gated;
    logic [3:0] count;

    typedef struct {
        int         cyc;
        logic [3:0] count;
        logic       theta;
        logic       p1;
        logic       p2;
        logic       gated;
    } exp_t;

    exp_t q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    bit   done      = 1'b0;

    always #5 clk = ~clk;

    tia_programmable_divider #(
        .WIDTH       (4),
        .DEFAULT_DIV (3)
    ) dut (
        .clk        (clk),
        .resphi0    (resphi0),
        .div        (div),
        .div_load   (div_load),
        .rsyn       (rsyn),
        .phi_theta  (phi_theta),
        .phi1       (phi1),
        .phi2       (phi2),
        .rsyn_gated (rsyn_gated),
        .count      (count)
    );

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL cyc%0d %s: got %0h expected %0h", c, name, act, exp);
    endtask

    // One stimulus cycle: drive inputs after the edge, push the expected view.
    task automatic cyc(input int c, input logic rst_in, input logic rs, input logic ld,
                       input logic [3:0] dv, input logic [3:0] ec, input logic et,
                       input logic e1, input logic e2, input logic eg);
        exp_t e;
        @(posedge clk);
        #1;
        resphi0  = rst_in;
        rsyn     = rs;
        div_load = ld;
        div      = dv;
        e.cyc = c; e.count = ec; e.theta = et; e.p1 = e1; e.p2 = e2; e.gated = eg;
        q.push_back(e);
    endtask

    task automatic idle(input int c, input logic [3:0] ec, input logic et,
                        input logic e1, input logic e2);
        cyc(c, 1'b0, 1'b0, 1'b0, 4'd0, ec, et, e1, e2, 1'b0);
    endtask

    // Monitor: the DUT presents a decoded phase every cycle.
    always @(negedge clk) begin
        if (!done && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("count",      e.cyc, 32'(count),      32'(e.count));
            chk("phi_theta",  e.cyc, 32'(phi_theta),  32'(e.theta));
            chk("phi1",       e.cyc, 32'(phi1),       32'(e.p1));
            chk("phi2",       e.cyc, 32'(phi2),       32'(e.p2));
            chk("rsyn_gated", e.cyc, 32'(rsyn_gated), 32'(e.gated));
            chk("no_overlap", e.cyc, 32'(phi1 & phi2), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resphi0 = 1'b1; rsyn = 1'b0; div_load = 1'b0; div = 4'd0;
        // Default ratio 3 after reset
        idle(1, 4'd0, 1, 1, 0);
        idle(2, 4'd1, 0, 0, 0);
        idle(3, 4'd2, 0, 0, 1);
        idle(4, 4'd0, 1, 1, 0);
        // div=4 loaded at count 1; current period still ends after 3
        cyc (5, 0, 0, 1, 4'd4, 4'd1, 0, 0, 0, 0);
        idle(6, 4'd2, 0, 0, 1);
        idle(7, 4'd0, 1, 1, 0);
        idle(8, 4'd1, 0, 1, 0);
        idle(9, 4'd2, 0, 0, 1);
        idle(10, 4'd3, 0, 0, 1);
        idle(11, 4'd0, 1, 1, 0);
        idle(12, 4'd1, 0, 1, 0);
        idle(13, 4'd2, 0, 0, 1);
        idle(14, 4'd3, 0, 0, 1);
        // div=0 clamps to 2, applied at next boundary
        cyc (15, 0, 0, 1, 4'd0, 4'd0, 1, 1, 0, 0);
        idle(16, 4'd1, 0, 1, 0);
        idle(17, 4'd2, 0, 0, 1);
        idle(18, 4'd3, 0, 0, 1);
        // div=1 also clamps to 2
        cyc (19, 0, 0, 1, 4'd1, 4'd0, 1, 1, 0, 0);
        idle(20, 4'd1, 0, 0, 1);
        idle(21, 4'd0, 1, 1, 0);
        idle(22, 4'd1, 0, 0, 1);
        idle(23, 4'd0, 1, 1, 0);
        // div=5 loaded on the boundary cycle applies immediately
        cyc (24, 0, 0, 1, 4'd5, 4'd1, 0, 0, 1, 0);
        idle(25, 4'd0, 1, 1, 0);
        // rsyn at count 1 of ratio 5
        cyc (26, 0, 1, 0, 4'd0, 4'd1, 0, 1, 0, 1);
        cyc (27, 0, 1, 0, 4'd0, 4'd0, 1, 1, 0, 0);
        idle(28, 4'd0, 1, 1, 0);
        idle(29, 4'd1, 0, 1, 0);
        // rsyn together with div_load=7 at the gap count of ratio 5
        cyc (30, 0, 1, 1, 4'd7, 4'd2, 0, 0, 0, 1);
        idle(31, 4'd0, 1, 1, 0);
        idle(32, 4'd1, 0, 1, 0);
        idle(33, 4'd2, 0, 1, 0);
        idle(34, 4'd3, 0, 0, 0);
        idle(35, 4'd4, 0, 0, 1);
        idle(36, 4'd5, 0, 0, 1);
        idle(37, 4'd6, 0, 0, 1);
        idle(38, 4'd0, 1, 1, 0);
        // rsyn held high pins count at 0
        cyc (39, 0, 1, 0, 4'd0, 4'd1, 0, 1, 0, 1);
        cyc (40, 0, 1, 0, 4'd0, 4'd0, 1, 1, 0, 0);
        cyc (41, 0, 1, 0, 4'd0, 4'd0, 1, 1, 0, 0);
        idle(42, 4'd0, 1, 1, 0);
        idle(43, 4'd1, 0, 1, 0);
        // reset with rsyn and div_load=9 at count 2: reset wins, 9 is lost
        cyc (44, 1, 1, 1, 4'd9, 4'd2, 0, 1, 0, 1);
        idle(45, 4'd0, 1, 1, 0);
        idle(46, 4'd1, 0, 0, 0);
        idle(47, 4'd2, 0, 0, 1);
        idle(48, 4'd0, 1, 1, 0);
        idle(49, 4'd1, 0, 0, 0);
        idle(50, 4'd2, 0, 0, 1);
        idle(51, 4'd0, 1, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        done = 1'b1;
        chk("queue_drained", 0, 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
